// File: rtl/q_update.sv
// Q-learning value-update engine: one fixed-point Bellman update per request,
// with the whole Q-table registered and exported for the action-selection stage.
module q_update #(
  parameter int N_STATES  = 37,
  parameter int N_ACTIONS = 4,
  parameter int Q_W       = 32,
  parameter int ALPHA_SH  = 2,
  parameter int GAMMA_SH  = 3,
  parameter logic signed [Q_W-1:0] REWARD_GOAL = 32'sh000A0000,
  parameter logic signed [Q_W-1:0] REWARD_STEP = 32'shFFFF0000,
  parameter logic signed [Q_W-1:0] REWARD_WALL = 32'shFFFE0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [5:0]            state,
  input  logic [3:0]            action,
  input  logic [5:0]            next_state,
  input  logic [5:0]            target_state,
  output logic                  busy,
  output logic                  done,
  output logic                  target_reached,
  output logic                  dropped,
  output logic [15:0]           episode_count,
  output logic signed [Q_W-1:0] q_table [N_STATES][N_ACTIONS]
);

  localparam int XW = Q_W + 2;
  localparam logic [5:0] LAST_ST  = 6'(N_STATES - 1);
  localparam logic [3:0] LAST_ACT = 4'(N_ACTIONS - 1);
  localparam logic signed [XW-1:0] QMAX_X = {3'b000, {(Q_W-1){1'b1}}};
  localparam logic signed [XW-1:0] QMIN_X = {3'b111, {(Q_W-1){1'b0}}};

  // Handshake: start is a single-cycle request taken only while busy is low;
  // done (with target_reached/dropped) is a one-cycle completion pulse.
  typedef enum logic [1:0] {IDLE, MAX, CALC, WRITE} fsm_t;
  fsm_t fsm, fsm_nxt;

  logic [5:0] st_r, ns_r, tg_r;
  logic [1:0] act_r, k;
  logic signed [Q_W-1:0] maxq;
  logic signed [XW-1:0]  delta;
  logic skip_term, skip_inv, skip_tr;

  logic in_invalid, in_terminal, accept;
  logic signed [Q_W-1:0] cur_q, cand_q, sat_q;
  logic signed [XW-1:0]  reward_x, maxq_x, cur_x, tgt_x, sum_x;

  assign busy   = (fsm != IDLE);
  assign accept = start && (fsm == IDLE);

  always_comb begin
    in_invalid  = (state == 6'd0) || (state > LAST_ST) ||
                  (next_state == 6'd0) || (next_state > LAST_ST) ||
                  (action > LAST_ACT);
    in_terminal = (state == target_state);
  end

  always_ff @(posedge clk) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:  if (accept && !in_invalid && !in_terminal) fsm_nxt = MAX;
      MAX:   if (k == 2'd3) fsm_nxt = CALC;
      CALC:  fsm_nxt = WRITE;
      WRITE: fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // Bellman arithmetic, all in Q_W+2 bits so the target cannot wrap.
  always_comb begin
    cur_q  = q_table[st_r][act_r];
    cand_q = q_table[ns_r][k];
    cur_x  = {{2{cur_q[Q_W-1]}}, cur_q};
    maxq_x = (ns_r == tg_r) ? '0 : {{2{maxq[Q_W-1]}}, maxq};
    if (ns_r == tg_r)      reward_x = {{2{REWARD_GOAL[Q_W-1]}}, REWARD_GOAL};
    else if (ns_r == st_r) reward_x = {{2{REWARD_WALL[Q_W-1]}}, REWARD_WALL};
    else                   reward_x = {{2{REWARD_STEP[Q_W-1]}}, REWARD_STEP};
    tgt_x = reward_x + maxq_x - (maxq_x >>> GAMMA_SH);
    sum_x = cur_x + (delta >>> ALPHA_SH);
    if (sum_x > QMAX_X)      sat_q = QMAX_X[Q_W-1:0];
    else if (sum_x < QMIN_X) sat_q = QMIN_X[Q_W-1:0];
    else                     sat_q = sum_x[Q_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N_STATES; r++)
        for (int c = 0; c < N_ACTIONS; c++)
          q_table[r][c] <= '0;
      episode_count  <= '0;
      done           <= 1'b0;
      target_reached <= 1'b0;
      dropped        <= 1'b0;
      skip_term      <= 1'b0;
      skip_inv       <= 1'b0;
      skip_tr        <= 1'b0;
      st_r  <= '0;
      ns_r  <= '0;
      tg_r  <= '0;
      act_r <= '0;
      k     <= '0;
      maxq  <= '0;
      delta <= '0;
    end else begin
      done           <= 1'b0;
      target_reached <= 1'b0;
      dropped        <= 1'b0;
      skip_term      <= 1'b0;
      skip_inv       <= 1'b0;
      // A skipped request completes one edge after it was accepted.
      if (skip_inv) begin
        done    <= 1'b1;
        dropped <= 1'b1;
      end else if (skip_term) begin
        done           <= 1'b1;
        target_reached <= skip_tr;
        episode_count  <= episode_count + 16'd1;
      end
      case (fsm)
        IDLE: if (accept) begin
          st_r      <= state;
          act_r     <= action[1:0];
          ns_r      <= next_state;
          tg_r      <= target_state;
          k         <= 2'd0;
          skip_inv  <= in_invalid;
          skip_term <= !in_invalid && in_terminal;
          skip_tr   <= (next_state == target_state);
        end
        MAX: begin
          if (k == 2'd0 || cand_q > maxq) maxq <= cand_q;
          k <= k + 2'd1;
        end
        CALC: delta <= tgt_x - cur_x;
        WRITE: begin
          q_table[st_r][act_r] <= sat_q;
          done                 <= 1'b1;
          target_reached       <= (ns_r == tg_r);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_q_update.sv
// Bench for q_update: vector table with a constant-driven table model, plus
// hand sequences for busy-time start, reset abort and back-to-back requests.
module tb_q_update;
  logic clk = 1'b0;
  logic rst, start;
  logic [5:0] state, next_state, target_state;
  logic [3:0] action;
  logic busy, done, target_reached, dropped;
  logic [15:0] episode_count;
  logic signed [31:0] q_table [37][4];

  q_update dut (
    .clk(clk), .rst(rst), .start(start), .state(state), .action(action),
    .next_state(next_state), .target_state(target_state), .busy(busy),
    .done(done), .target_reached(target_reached), .dropped(dropped),
    .episode_count(episode_count), .q_table(q_table)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  st;
    logic [3:0]  act;
    logic [5:0]  ns;
    logic [5:0]  tg;
    logic        wr;
    int          row;
    int          col;
    logic [31:0] val;
    logic [7:0]  lat;
    logic        tr;
    logic        dr;
    logic [15:0] ep;
  } vec_t;

  vec_t vecs [12];
  logic [31:0] model [37][4];
  logic [9:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_table(input string name);
    int bad = 0;
    int br = 0, bc = 0;
    for (int r = 0; r < 37; r++)
      for (int c = 0; c < 4; c++)
        if (q_table[r][c] !== model[r][c]) begin
          if (bad == 0) begin br = r; bc = c; end
          bad++;
        end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d entries differ, first q[%0d][%0d] got 0x%0h expected 0x%0h",
               name, bad, br, bc, q_table[br][bc], model[br][bc]);
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < 37; r++)
      for (int c = 0; c < 4; c++)
        model[r][c] = '0;
  endtask

  task automatic drive(input logic [5:0] s, input logic [3:0] a,
                       input logic [5:0] n, input logic [5:0] t);
    state = s; action = a; next_state = n; target_state = t; start = 1'b1;
  endtask

  // Wait at negedges until done; returns cycles since the accepting edge.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    logic [9:0] e;
    @(negedge clk);
    drive(v.st, v.act, v.ns, v.tg);
    exp_q.push_back({v.tr, v.dr, v.lat});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d busy", idx), 64'(busy), 64'(v.lat != 8'd1));
    wait_done(cyc);
    e = exp_q.pop_front();
    chk($sformatf("v%0d latency", idx), 64'(cyc), 64'(e[7:0]));
    chk($sformatf("v%0d target_reached", idx), 64'(target_reached), 64'(e[9]));
    chk($sformatf("v%0d dropped", idx), 64'(dropped), 64'(e[8]));
    if (v.wr) model[v.row][v.col] = v.val;
    chk_table($sformatf("v%0d table", idx));
    @(negedge clk);
    chk($sformatf("v%0d done pulse", idx), 64'(done), 64'd0);
    chk($sformatf("v%0d episode", idx), 64'(episode_count), 64'(v.ep));
  endtask

  initial begin
    int cyc, ndone;
    //        st   act  ns   tg   wr  row col  val            lat tr  dr  ep
    vecs[0]  = '{6'd35, 4'd1, 6'd36, 6'd36, 1, 35, 1, 32'h00028000, 8'd6, 1, 0, 16'd0};
    vecs[1]  = '{6'd34, 4'd1, 6'd35, 6'd36, 1, 34, 1, 32'h00004C00, 8'd6, 0, 0, 16'd0};
    vecs[2]  = '{6'd35, 4'd1, 6'd36, 6'd36, 1, 35, 1, 32'h00046000, 8'd6, 1, 0, 16'd0};
    vecs[3]  = '{6'd1,  4'd2, 6'd1,  6'd36, 1, 1,  2, 32'hFFFF8000, 8'd6, 0, 0, 16'd0};
    vecs[4]  = '{6'd2,  4'd0, 6'd1,  6'd36, 1, 2,  0, 32'hFFFFC000, 8'd6, 0, 0, 16'd0};
    vecs[5]  = '{6'd36, 4'd0, 6'd5,  6'd36, 0, 0,  0, 32'h0,        8'd1, 0, 0, 16'd1};
    vecs[6]  = '{6'd10, 4'd5, 6'd11, 6'd36, 0, 0,  0, 32'h0,        8'd1, 0, 1, 16'd1};
    vecs[7]  = '{6'd0,  4'd0, 6'd1,  6'd36, 0, 0,  0, 32'h0,        8'd1, 0, 1, 16'd1};
    vecs[8]  = '{6'd3,  4'd0, 6'd37, 6'd36, 0, 0,  0, 32'h0,        8'd1, 0, 1, 16'd1};
    vecs[9]  = '{6'd33, 4'd3, 6'd34, 6'd36, 1, 33, 3, 32'hFFFFD0A0, 8'd6, 0, 0, 16'd1};
    vecs[10] = '{6'd1,  4'd2, 6'd1,  6'd36, 1, 1,  2, 32'hFFFF2000, 8'd6, 0, 0, 16'd1};
    vecs[11] = '{6'd20, 4'd0, 6'd21, 6'd20, 0, 0,  0, 32'h0,        8'd1, 0, 0, 16'd2};

    rst = 1'b1; start = 1'b0;
    state = '0; action = '0; next_state = '0; target_state = '0;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset target_reached", 64'(target_reached), 64'd0);
    chk("reset dropped", 64'(dropped), 64'd0);
    chk("reset episode", 64'(episode_count), 64'd0);
    chk_table("reset table");

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // start arriving while busy is ignored: only one done, no second write
    @(negedge clk);
    drive(6'd5, 4'd0, 6'd6, 6'd36);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 2) drive(6'd7, 4'd0, 6'd8, 6'd36);
      if (c == 3) start = 1'b0;
      if (done) ndone++;
    end
    model[5][0] = 32'hFFFFC000;
    chk("busy start done count", 64'(ndone), 64'd1);
    chk_table("busy start table");

    // back-to-back: start held in the done cycle is accepted
    @(negedge clk);
    drive(6'd12, 4'd0, 6'd13, 6'd36);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chk("b2b first latency", 64'(cyc), 64'd6);
    drive(6'd14, 4'd0, 6'd15, 6'd36);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b second accepted", 64'(busy), 64'd1);
    wait_done(cyc);
    chk("b2b second latency", 64'(cyc), 64'd6);
    model[12][0] = 32'hFFFFC000;
    model[14][0] = 32'hFFFFC000;
    chk_table("b2b table");

    // reset in the middle of an update: no write, no done
    @(negedge clk);
    drive(6'd1, 4'd3, 6'd2, 6'd36);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort done count", 64'(ndone), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort episode", 64'(episode_count), 64'd0);
    chk_table("abort table");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
